// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// keypad_scan_ctrl : 4x4 keypad column scanner with debounce and valid/ack key output
// Revision 1.0
// ============================================================================
module keypad_scan_ctrl #(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int RELEASE_TICKS  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [3:0] col_o,
  input  logic [3:0] row_i,
  output logic       timer_rst_no,
  input  logic       timer_done_i,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  input  logic       key_ack_i
);

  localparam int MAX_TICKS = (DEBOUNCE_TICKS > RELEASE_TICKS) ? DEBOUNCE_TICKS : RELEASE_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    REPORT   = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [3:0]       rs_meta_q;
  logic [3:0]       rs_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       row_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rcnt_q;
  logic [3:0]       col_q;
  logic [3:0]       key_q;
  logic             key_valid_q;
  logic             timer_rst_nq;

  logic [3:0]       row_low;
  logic             single_low;
  logic [1:0]       row_enc;
  logic             sample;
  logic [1:0]       col_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] rcnt_inc;

  assign row_low    = ~rs_q;
  assign single_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
  // Done is still sticky from the previous period while the restart pulse is out.
  assign sample     = timer_done_i & timer_rst_nq;
  assign col_next   = col_idx_q + 2'd1;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign rcnt_inc   = rcnt_q + CNT_W'(1);

  always_comb begin
    row_enc = 2'd0;
    case (row_low)
      4'b0010: row_enc = 2'd1;
      4'b0100: row_enc = 2'd2;
      4'b1000: row_enc = 2'd3;
      default: row_enc = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SCAN;
      rs_meta_q    <= 4'b1111;
      rs_q         <= 4'b1111;
      col_idx_q    <= 2'd0;
      row_idx_q    <= 2'd0;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      col_q        <= 4'b1111;
      key_q        <= 4'd0;
      key_valid_q  <= 1'b0;
      timer_rst_nq <= 1'b0;
    end else begin
      rs_meta_q    <= row_i;
      rs_q         <= rs_meta_q;
      timer_rst_nq <= 1'b1;
      col_q        <= ~(4'b0001 << col_idx_q);
      case (state_q)
        SCAN: begin
          if (sample) begin
            timer_rst_nq <= 1'b0;
            if (single_low) begin
              row_idx_q <= row_enc;
              cnt_q     <= CNT_W'(1);
              if (DEBOUNCE_TICKS == 1) begin
                key_q       <= {row_enc, col_idx_q};
                key_valid_q <= 1'b1;
                state_q     <= REPORT;
              end else begin
                state_q <= DEBOUNCE;
              end
            end else begin
              col_idx_q <= col_next;
              col_q     <= ~(4'b0001 << col_next);
            end
          end
        end
        DEBOUNCE: begin
          if (sample) begin
            if (single_low && (row_enc == row_idx_q)) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == DEB_LAST) begin
                key_q       <= {row_idx_q, col_idx_q};
                key_valid_q <= 1'b1;
                state_q     <= REPORT;
              end else begin
                timer_rst_nq <= 1'b0;
              end
            end else begin
              cnt_q        <= '0;
              timer_rst_nq <= 1'b0;
              state_q      <= SCAN;
            end
          end
        end
        REPORT: begin
          if (key_valid_q && key_ack_i) begin
            key_valid_q  <= 1'b0;
            timer_rst_nq <= 1'b0;
            rcnt_q       <= '0;
            state_q      <= RELEASE;
          end
        end
        default: begin
          if (sample) begin
            timer_rst_nq <= 1'b0;
            if (rs_q == 4'b1111) begin
              if (rcnt_inc == REL_LAST) begin
                rcnt_q    <= '0;
                col_idx_q <= col_next;
                col_q     <= ~(4'b0001 << col_next);
                state_q   <= SCAN;
              end else begin
                rcnt_q <= rcnt_inc;
              end
            end else begin
              // Key still held: keep waiting, never re-report it.
              rcnt_q <= '0;
            end
          end
        end
      endcase
    end
  end

  assign col_o        = col_q;
  assign timer_rst_no = timer_rst_nq;
  assign key_o        = key_q;
  assign key_valid_o  = key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keypad_scan_ctrl : directed bench with keypad matrix and settle-timer models
// Revision 1.0
// ============================================================================
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic       timer_rst_n;
  logic       timer_done;
  logic [3:0] key;
  logic       key_valid;
  logic       key_ack;

  logic [3:0] pressed [4];
  logic [3:0] tcnt;
  int         checks;
  int         errors;
  int         valid_cycles;
  logic [3:0] exp_q [$];

  keypad_scan_ctrl #(.DEBOUNCE_TICKS(2), .RELEASE_TICKS(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .col_o        (col),
    .row_i        (row),
    .timer_rst_no (timer_rst_n),
    .timer_done_i (timer_done),
    .key_o        (key),
    .key_valid_o  (key_valid),
    .key_ack_i    (key_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Done rises 8 cycles after the restart is released and stays high until the next restart.
  always @(posedge clk) begin
    if (!timer_rst_n) begin
      tcnt       <= 4'd0;
      timer_done <= 1'b0;
    end else begin
      if (tcnt < 4'd8) tcnt <= tcnt + 4'd1;
      timer_done <= (tcnt >= 4'd7);
    end
  end

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if ((pressed[r] & ~col) != 4'd0) row[r] = 1'b0;
    end
  end

  always @(posedge clk) if (key_valid === 1'b1) valid_cycles <= valid_cycles + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, 32'(col), 32'hF);
    check({tag, "_trst"}, 32'(timer_rst_n), 32'h0);
    check({tag, "_key"}, 32'(key), 32'h0);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
  endtask

  task automatic wait_col(input logic [3:0] exp, input int budget, input string tag);
    int n;
    n = 0;
    while (col !== exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(col), 32'(exp));
  endtask

  task automatic step_col(input logic [3:0] exp, input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (timer_rst_n === 1'b0) pulses++;
      if (col === exp) break;
    end
    check({tag, "_col"}, 32'(col), 32'(exp));
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  task automatic wait_pulse(input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (timer_rst_n === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    logic [3:0] e;
    for (int i = 0; i < budget; i++) begin
      if (key_valid === 1'b1) break;
      tick();
    end
    check({tag, "_valid"}, 32'(key_valid), 32'd1);
    check({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_key"}, 32'(key), 32'(e));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int vc;
    checks       = 0;
    errors       = 0;
    valid_cycles = 0;
    rst_n        = 1'b0;
    key_ack      = 1'b0;
    for (int r = 0; r < 4; r++) pressed[r] = 4'd0;

    // 1: idle scan
    repeat (3) tick();
    check_reset_outputs("t1_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t1_col0", 32'(col), 32'hE);
    key_ack = 1'b1;
    step_col(4'b1101, "t1_c1");
    step_col(4'b1011, "t1_c2");
    step_col(4'b0111, "t1_c3");
    key_ack = 1'b0;
    step_col(4'b1110, "t1_c0");
    check("t1_no_valid", 32'(valid_cycles), 32'd0);

    // 2: key row 2 / column 1
    pressed[2] = 4'b0010;
    exp_q.push_back(4'b1001);
    wait_valid(200, "t2");
    check("t2_col", 32'(col), 32'hD);
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    check("t2_ack_drop", 32'(key_valid), 32'd0);
    bad = 0;
    repeat (60) begin
      tick();
      if (key_valid !== 1'b0 || col !== 4'b1101) bad++;
    end
    check("t2_held_no_repeat", 32'(bad), 32'd0);
    pressed[2] = 4'd0;
    wait_col(4'b1011, 60, "t2_resume_c2");

    // 3: one-sample bounce
    vc = valid_cycles;
    wait_col(4'b1101, 60, "t3_c1");
    pressed[2] = 4'b0010;
    wait_pulse(30, "t3_sample1");
    check("t3_col_deb", 32'(col), 32'hD);
    pressed[2] = 4'd0;
    wait_pulse(30, "t3_sample2");
    check("t3_same_col", 32'(col), 32'hD);
    wait_pulse(30, "t3_sample3");
    check("t3_advance", 32'(col), 32'hB);
    check("t3_no_valid", 32'(valid_cycles), 32'(vc));

    // 4: two rows low in column 0
    wait_col(4'b1110, 60, "t4_c0");
    pressed[2] = 4'b0001;
    pressed[3] = 4'b0001;
    wait_pulse(30, "t4_sample1");
    check("t4_adv1", 32'(col), 32'hD);
    wait_col(4'b1110, 60, "t4_c0_again");
    wait_pulse(30, "t4_sample2");
    check("t4_adv2", 32'(col), 32'hD);
    check("t4_no_valid", 32'(valid_cycles), 32'(vc));
    pressed[2] = 4'd0;
    pressed[3] = 4'd0;

    // 5: key 0 held unacknowledged, then ack held high with key still down
    pressed[0] = 4'b0001;
    exp_q.push_back(4'b0000);
    wait_valid(200, "t5");
    bad = 0;
    repeat (100) begin
      tick();
      if (key_valid !== 1'b1 || key !== 4'b0000) bad++;
    end
    check("t5_stable", 32'(bad), 32'd0);
    key_ack = 1'b1;
    bad = 0;
    repeat (60) begin
      tick();
      if (key_valid !== 1'b0) bad++;
    end
    key_ack = 1'b0;
    check("t5_single_accept", 32'(bad), 32'd0);
    pressed[0] = 4'd0;
    wait_col(4'b1101, 60, "t5_resume_c1");

    // 6a: reset during debounce
    wait_col(4'b1110, 60, "t6_c0");
    pressed[1] = 4'b0001;
    wait_pulse(30, "t6_deb_entry");
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6a");
    pressed[1] = 4'd0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6a_restart_c0", 32'(col), 32'hE);

    // 6b: reset while a key is being reported
    pressed[1] = 4'b0001;
    exp_q.push_back(4'b0100);
    wait_valid(200, "t6b");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6b");
    pressed[1] = 4'd0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6b_restart_c0", 32'(col), 32'hE);
    step_col(4'b1101, "t6b_c1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
